// File: rtl/seg_message_sequencer.sv
// -----------------------------------------------------------------------------
// seg_message_sequencer
//
// Stores a short message of 6-bit character codes and plays it back one entry
// at a time, each entry held on the output for DIV clock cycles, looping
// forever while play is high. The output feeds a 7-segment character decoder.
// When nothing is playing the IDLE_CODE is driven so the decoder shows a dash.
//
// States:
//   IDLE : not playing; writes allowed; code = IDLE_CODE
//   SHOW : playing; divider counts, idx advances; writes ignored
//   HOLD : paused; idx and divider frozen; writes allowed (extend the message)
//
// Ports:
//   clk_2      in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   append wr_data to the message (IDLE or HOLD, not full)
//   wr_data    in   6-bit character code, stored without range check
//   clear      in   empty the message and return to IDLE (highest priority)
//   play       in   level: 1 = run, 0 = pause
//   code       out  current code for the decoder (combinational)
//   code_valid out  high in SHOW or HOLD (combinational)
//   idx        out  index of the entry being shown
//   count      out  number of stored entries
//   full       out  count == DEPTH (combinational)
//   wrap       out  registered one-cycle pulse when idx returns to 0
//
// DEPTH must be at least 2 so idx has a non-zero width.
// -----------------------------------------------------------------------------
module seg_message_sequencer #(
    parameter int         DEPTH     = 8,
    parameter int         DIV       = 4,
    parameter logic [5:0] IDLE_CODE = 6'd63
) (
    input  logic                       clk_2,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [5:0]                 wr_data,
    input  logic                       clear,
    input  logic                       play,
    output logic [5:0]                 code,
    output logic                       code_valid,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       wrap
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [5:0]      msg_mem [DEPTH];

    logic            wr_accept;
    logic            div_last;
    logic            idx_last;

    // Writes are refused while playing so the entry being shown never changes
    // underneath the display; clear wins over everything.
    assign wr_accept = wr_en && !full && !clear && (state != ST_SHOW);
    assign div_last  = (div_cnt == DW'(DIV - 1));
    assign idx_last  = ({1'b0, idx} == (count - CW'(1)));

    assign full       = (count == CW'(DEPTH));
    assign code_valid = (state != ST_IDLE);
    assign code       = (state == ST_IDLE) ? IDLE_CODE : msg_mem[idx];

    // NOTE: the message storage has no reset; count alone decides which
    // entries are valid, so resetting the array would only cost logic.
    always_ff @(posedge clk_2) begin
        if (wr_accept) begin
            msg_mem[count[IW-1:0]] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            idx     <= '0;
            div_cnt <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                state   <= ST_IDLE;
                count   <= '0;
                idx     <= '0;
                div_cnt <= '0;
            end else begin
                if (wr_accept) begin
                    count <= count + CW'(1);
                end
                case (state)
                    ST_IDLE: begin
                        if (play && (count != '0)) begin
                            state   <= ST_SHOW;
                            idx     <= '0;
                            div_cnt <= '0;
                        end
                    end
                    ST_SHOW, ST_HOLD: begin
                        // A cycle with play high always counts toward the
                        // current entry, including the one that leaves HOLD,
                        // so an entry gets DIV play-high cycles in total no
                        // matter where a pause fell.
                        if (play) begin
                            state <= ST_SHOW;
                            if (div_last) begin
                                div_cnt <= '0;
                                idx     <= idx_last ? '0 : idx + IW'(1);
                                wrap    <= idx_last;
                            end else begin
                                div_cnt <= div_cnt + DW'(1);
                            end
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_message_sequencer.sv
// -----------------------------------------------------------------------------
// tb_seg_message_sequencer
//
// Directed scenarios followed by a randomized run, each cycle compared against
// a behavioural model that keeps the message in a queue and tracks the shown
// position and elapsed ticks with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seg_message_sequencer;

    localparam int         DEPTH     = 8;
    localparam int         DIV       = 4;
    localparam logic [5:0] IDLE_CODE = 6'd63;

    logic        clk_2 = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [5:0]  wr_data;
    logic        clear;
    logic        play;
    logic [5:0]  code;
    logic        code_valid;
    logic [2:0]  idx;
    logic [3:0]  count;
    logic        full;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    seg_message_sequencer #(
        .DEPTH     (DEPTH),
        .DIV       (DIV),
        .IDLE_CODE (IDLE_CODE)
    ) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clear      (clear),
        .play       (play),
        .code       (code),
        .code_valid (code_valid),
        .idx        (idx),
        .count      (count),
        .full       (full),
        .wrap       (wrap)
    );

    always #5 clk_2 = ~clk_2;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_SHOW, M_HOLD} mode_t;

    mode_t      m_mode;
    logic [5:0] m_msg[$];
    int         m_pos;
    int         m_ticks;
    bit         m_wrap;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_msg.delete();
        m_pos   = 0;
        m_ticks = 0;
        m_wrap  = 0;
    endtask

    // One rising edge with the given inputs.
    task automatic model_step(input bit we, input logic [5:0] wd,
                              input bit cl, input bit pl);
        int  len;
        bit  take;
        len    = m_msg.size();
        m_wrap = 0;
        if (cl) begin
            m_msg.delete();
            m_mode  = M_IDLE;
            m_pos   = 0;
            m_ticks = 0;
        end else begin
            take = we && (len < DEPTH) && (m_mode != M_SHOW);
            if (m_mode == M_IDLE) begin
                if (pl && len > 0) begin
                    m_mode  = M_SHOW;
                    m_pos   = 0;
                    m_ticks = 0;
                end
            end else if (pl) begin
                m_mode  = M_SHOW;
                m_ticks = m_ticks + 1;
                if (m_ticks == DIV) begin
                    m_ticks = 0;
                    m_pos   = (m_pos + 1) % len;
                    m_wrap  = (m_pos == 0);
                end
            end else begin
                m_mode = M_HOLD;
            end
            if (take) m_msg.push_back(wd);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0] exp_code;
        exp_code = (m_mode == M_IDLE) ? IDLE_CODE : m_msg[m_pos];
        check({tag, ".code"},       32'(code),       32'(exp_code));
        check({tag, ".code_valid"}, 32'(code_valid), 32'(m_mode != M_IDLE));
        check({tag, ".idx"},        32'(idx),        32'(m_pos));
        check({tag, ".count"},      32'(count),      32'(m_msg.size()));
        check({tag, ".full"},       32'(full),       32'(m_msg.size() == DEPTH));
        check({tag, ".wrap"},       32'(wrap),       32'(m_wrap));
    endtask

    // Drive inputs, take one edge, then compare everything 1 time unit later.
    task automatic tick(input string tag, input bit we, input logic [5:0] wd,
                        input bit cl, input bit pl);
        wr_en   = we;
        wr_data = wd;
        clear   = cl;
        play    = pl;
        @(posedge clk_2);
        model_step(we, wd, cl, pl);
        #1;
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] seq_vals [4];

    initial begin
        seq_vals[0] = 6'd33; seq_vals[1] = 6'd16;
        seq_vals[2] = 6'd31; seq_vals[3] = 6'd21;

        // Reset
        reset_n = 1'b0;
        wr_en = 0; wr_data = 0; clear = 0; play = 0;
        model_reset();
        repeat (2) @(posedge clk_2);
        #1;
        check_all("reset");
        #3 reset_n = 1'b1;

        // Write four entries while paused: stays IDLE
        for (int i = 0; i < 4; i++) tick("wr4", 1, seq_vals[i], 0, 0);
        check("wr4.count_lit", 32'(count), 32'd4);
        check("wr4.code_lit",  32'(code),  32'd63);

        // Play the four entries: 4 cycles each, wrap on the second 33
        for (int k = 0; k < 17; k++) begin
            tick("play4", 0, 0, 0, 1);
            check("play4.code_lit", 32'(code), 32'(seq_vals[(k / DIV) % 4]));
            check("play4.wrap_lit", 32'(wrap), 32'(k == 16));
        end

        // Fill, then a ninth write is ignored
        tick("clr", 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) tick("fill", 1, 6'(i + 40), 0, 0);
        tick("ninth", 1, 6'd5, 0, 0);
        check("ninth.full_lit",  32'(full),  32'd1);
        check("ninth.count_lit", 32'(count), 32'd8);

        // Clear wins over a simultaneous write
        tick("clr_wr", 1, 6'd9, 1, 1);
        check("clr_wr.count_lit", 32'(count), 32'd0);
        check("clr_wr.full_lit",  32'(full),  32'd0);

        // Pause at divider 2 on entry 1, write in HOLD, resume
        for (int i = 0; i < 4; i++) tick("msg", 1, 6'(10 + i), 0, 0);
        for (int i = 0; i < 7; i++) tick("run", 0, 0, 0, 1);
        tick("pause", 0, 0, 0, 0);
        check("pause.code_lit", 32'(code), 32'd11);
        tick("hold_wr", 1, 6'd5, 0, 0);
        check("hold_wr.count_lit", 32'(count), 32'd5);
        check("hold_wr.idx_lit",   32'(idx),   32'd1);
        tick("resume", 0, 0, 0, 1);
        check("resume.code_lit", 32'(code), 32'd11);
        tick("adv", 0, 0, 0, 1);
        check("adv.idx_lit",  32'(idx),  32'd2);
        check("adv.code_lit", 32'(code), 32'd12);

        // Single entry: constant code, wrap every DIV cycles
        tick("clr1", 0, 0, 1, 0);
        tick("one", 1, 6'd7, 0, 0);
        for (int k = 0; k < 13; k++) begin
            tick("single", 0, 0, 0, 1);
            check("single.code_lit", 32'(code), 32'd7);
            check("single.wrap_lit", 32'(wrap), 32'(k > 0 && (k % DIV) == 0));
        end

        // Asynchronous reset between edges while in SHOW
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("async.code_lit",  32'(code),       32'd63);
        check("async.valid_lit", 32'(code_valid), 32'd0);
        check_all("async");
        @(posedge clk_2);
        #3 reset_n = 1'b1;
        tick("post_rst", 0, 0, 0, 1);
        check("post_rst.valid_lit", 32'(code_valid), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            bit         we, cl, pl;
            logic [5:0] wd;
            we = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 99) < 3);
            pl = ($urandom_range(0, 99) < 75);
            wd = 6'($urandom_range(0, 63));
            tick("rand", we, wd, cl, pl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
